// File: rtl/serial_demux_deserializer_pkg.sv
// Shared width helper for the two-channel serial deserializer.
package serial_demux_deserializer_pkg;

  // Counter width for a WIDTH-bit word. It is never narrower than 1 bit, so WIDTH=2 still gets a usable counter.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/demux_1x1.sv
// 1-to-2 bit demultiplexer: key=0 steers data to out1, key=1 to out2, gated by enable.
module demux_1x1 (
  input  logic data,
  input  logic key,
  input  logic enable,
  output logic out1,
  output logic out2
);

  assign out1 = enable & ~key & data;
  assign out2 = enable &  key & data;

endmodule

// File: rtl/serial_demux_deserializer_channel.sv
// One deserializer lane: LSB-first shift register, bit counter, and registered word/valid.
module serial_demux_deserializer_channel
  import serial_demux_deserializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_strobe,
  input  logic             i_bit,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_word;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      // Flush wins over a coincident strobe; the completed word is left alone.
      if (i_flush) begin
        r_shreg <= '0;
        r_cnt   <= '0;
      end else if (i_strobe) begin
        if (r_cnt == LAST) begin
          r_word  <= {i_bit, r_shreg[WIDTH-1:1]};
          r_valid <= 1'b1;
          r_shreg <= '0;
          r_cnt   <= '0;
        end else begin
          r_shreg <= {i_bit, r_shreg[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_word  = r_word;
  assign o_valid = r_valid;
  assign o_count = r_cnt;

endmodule

// File: rtl/serial_demux_deserializer.sv
// Two-channel serial-to-parallel receiver. A demux_1x1 turns enable/key into per-channel strobes.
module serial_demux_deserializer
  import serial_demux_deserializer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             data,
  input  logic             key,
  input  logic             enable,
  input  logic             flush,
  output logic [WIDTH-1:0] word1,
  output logic [WIDTH-1:0] word2,
  output logic             valid1,
  output logic             valid2,
  output logic [CW-1:0]    count1,
  output logic [CW-1:0]    count2
);

  logic w_strobe1;
  logic w_strobe2;

  // The demux data input is tied high, so its outputs act as pure strobes.
  // The bit value itself comes straight from the data input.
  demux_1x1 u_demux (
    .data   (1'b1),
    .key    (key),
    .enable (enable),
    .out1   (w_strobe1),
    .out2   (w_strobe2)
  );

  serial_demux_deserializer_channel #(.WIDTH(WIDTH), .CW(CW)) u_ch1 (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_strobe (w_strobe1),
    .i_bit    (data),
    .i_flush  (flush),
    .o_word   (word1),
    .o_valid  (valid1),
    .o_count  (count1)
  );

  serial_demux_deserializer_channel #(.WIDTH(WIDTH), .CW(CW)) u_ch2 (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_strobe (w_strobe2),
    .i_bit    (data),
    .i_flush  (flush),
    .o_word   (word2),
    .o_valid  (valid2),
    .o_count  (count2)
  );

endmodule

// File: tb/tb_serial_demux_deserializer.sv
// Bench for serial_demux_deserializer: bit-queue reference model, a per-cycle compare, directed and random stimulus.
module tb_serial_demux_deserializer;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          data = 1'b0, key = 1'b0, enable = 1'b0, flush = 1'b0;
  logic [W-1:0]  word1, word2;
  logic          valid1, valid2;
  logic [CW-1:0] count1, count2;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  serial_demux_deserializer #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .data(data), .key(key), .enable(enable),
    .flush(flush), .word1(word1), .word2(word2), .valid1(valid1), .valid2(valid2),
    .count1(count1), .count2(count2)
  );

  always #5 clock = ~clock;

  // Reference model. Each channel keeps the bits it has received so far in a queue.
  // A word is formed once the queue holds W bits, with the first bit received as the LSB.
  bit           q1[$];
  bit           q2[$];
  logic [W-1:0] m_word1 = '0, m_word2 = '0;
  bit           m_valid1 = 0, m_valid2 = 0;

  function automatic logic [W-1:0] pack(input bit q[$]);
    logic [W-1:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = v | (W'(q[i]) << i);
    return v;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1.delete(); q2.delete();
      m_word1 = '0; m_word2 = '0; m_valid1 = 0; m_valid2 = 0;
    end else begin
      m_valid1 = 0; m_valid2 = 0;
      if (flush) begin
        q1.delete(); q2.delete();
      end else if (enable) begin
        if (!key) begin
          q1.push_back(data);
          if (q1.size() == W) begin m_word1 = pack(q1); m_valid1 = 1; q1.delete(); end
        end else begin
          q2.push_back(data);
          if (q2.size() == W) begin m_word2 = pack(q2); m_valid2 = 1; q2.delete(); end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (run_cmp) begin
      chk("model word1",  32'(word1),  32'(m_word1));
      chk("model word2",  32'(word2),  32'(m_word2));
      chk("model valid1", 32'(valid1), 32'(m_valid1));
      chk("model valid2", 32'(valid2), 32'(m_valid2));
      chk("model count1", 32'(count1), q1.size());
      chk("model count2", 32'(count2), q2.size());
    end
  end

  task automatic send_bit(input logic k, input logic d, input logic fl);
    @(negedge clock);
    enable = 1'b1; key = k; data = d; flush = fl;
  endtask

  task automatic idle();
    @(negedge clock);
    enable = 1'b0; flush = 1'b0; key = 1'($urandom); data = 1'($urandom);
  endtask

  task automatic send_word(input logic k, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) send_bit(k, w[i], 1'b0);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, " word1"},  32'(word1),  0);
    chk({tag, " word2"},  32'(word2),  0);
    chk({tag, " valid1"}, 32'(valid1), 0);
    chk({tag, " valid2"}, 32'(valid2), 0);
    chk({tag, " count1"}, 32'(count1), 0);
    chk({tag, " count2"}, 32'(count2), 0);
  endtask

  initial begin
    logic [7:0] a = 8'h3C, b = 8'hC3;
    // Reset with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      data = 1'($urandom); key = 1'($urandom); enable = 1'($urandom); flush = 1'($urandom);
    end
    zero_outputs("reset");
    enable = 1'b0; flush = 1'b0;
    reset_n = 1'b1;
    run_cmp = 1'b1;

    // Channel 1: send 8'hA5, least significant bit first.
    send_word(1'b0, 8'hA5);
    idle();
    chk("ch1 word1", 32'(word1), 32'hA5);
    chk("ch1 valid1 pulse", 32'(valid1), 1);
    chk("ch1 word2 untouched", 32'(word2), 0);
    idle();
    chk("ch1 valid1 drop", 32'(valid1), 0);

    // Interleave the two channels: channel 1 carries 3C and channel 2 carries C3.
    for (int i = 0; i < W; i++) begin
      send_bit(1'b0, a[i], 1'b0);
      if (i == W-1) begin
        send_bit(1'b1, b[i], 1'b0);
        chk("ilv valid1 first", 32'(valid1), 1);
        chk("ilv valid2 not yet", 32'(valid2), 0);
      end else send_bit(1'b1, b[i], 1'b0);
    end
    idle();
    chk("ilv valid2 next", 32'(valid2), 1);
    chk("ilv valid1 gone", 32'(valid1), 0);
    chk("ilv word1", 32'(word1), 32'h3C);
    chk("ilv word2", 32'(word2), 32'hC3);

    // Gaps: send FF on channel 2 with three idle cycles between bits.
    for (int i = 0; i < W; i++) begin
      send_bit(1'b1, 1'b1, 1'b0);
      idle();
      chk("gap count2", 32'(count2), (i + 1) % W);
      if (i == W-1) chk("gap valid2", 32'(valid2), 1);
      idle(); idle();
    end
    chk("gap word2", 32'(word2), 32'hFF);

    // Flush in the middle of a word. The flush arrives together with a strobe, which must be dropped.
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b1);
    idle();
    chk("flush count1", 32'(count1), 0);
    chk("flush word1 kept", 32'(word1), 32'h3C);
    send_word(1'b0, 8'h0F);
    idle();
    chk("flush word1", 32'(word1), 32'h0F);

    // Asynchronous reset between clock edges, after 5 bits on channel 2.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'(i), 1'b0);
    idle();
    chk("pre-rst count2", 32'(count2), 5);
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    zero_outputs("async rst");
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    send_word(1'b1, 8'h81);
    idle();
    chk("post-rst word2", 32'(word2), 32'h81);
    chk("post-rst valid2", 32'(valid2), 1);

    // Random traffic, checked against the model on every cycle.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      enable = ($urandom_range(0, 3) != 0);
      key    = 1'($urandom);
      data   = 1'($urandom);
      flush  = ($urandom_range(0, 29) == 0);
    end
    idle(); idle();
    run_cmp = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
